// File: rtl/wb_shared_arbiter.sv
// wb_shared_arbiter: round-robin two-master Wishbone arbiter with
// tenure locking on cyc and a watchdog on unacknowledged strobes.
module wb_shared_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   output logic [31:0] m0_dat_o,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [31:0] m1_dat_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   output logic [1:0]  grant_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   localparam logic [15:0] TLIM = 16'(TIMEOUT - 1);

   state_t      state, state_d;
   logic        last, last_d;
   logic [15:0] tcnt, tcnt_d;
   logic        req0, req1;
   logic        tmo;

   assign req0 = m0_cyc_i & m0_stb_i;
   assign req1 = m1_cyc_i & m1_stb_i;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state <= IDLE;
         last  <= 1'b1;
         tcnt  <= '0;
      end else begin
         state <= state_d;
         last  <= last_d;
         tcnt  <= tcnt_d;
      end
   end

   always_comb begin
      state_d  = state;
      last_d   = last;
      tcnt_d   = '0;
      tmo      = 1'b0;
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_sel_o  = '0;
      s_adr_o  = '0;
      s_dat_o  = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m0_dat_o = '0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      m1_dat_o = '0;
      unique case (state)
         IDLE: begin
            // on a tie the master that did not go last wins
            if (req0 && (!req1 || last))
               state_d = OWN0;
            else if (req1)
               state_d = OWN1;
         end
         OWN0: begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            tmo      = m0_stb_i & ~s_ack_i & (tcnt == TLIM);
            m0_ack_o = s_ack_i;
            m0_err_o = tmo;
            m0_dat_o = s_dat_i;
            if (m0_stb_i & ~s_ack_i & ~tmo)
               tcnt_d = tcnt + 16'd1;
            if (!m0_cyc_i) begin
               state_d = IDLE;
               last_d  = 1'b0;
            end
         end
         OWN1: begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            tmo      = m1_stb_i & ~s_ack_i & (tcnt == TLIM);
            m1_ack_o = s_ack_i;
            m1_err_o = tmo;
            m1_dat_o = s_dat_i;
            if (m1_stb_i & ~s_ack_i & ~tmo)
               tcnt_d = tcnt + 16'd1;
            if (!m1_cyc_i) begin
               state_d = IDLE;
               last_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign grant_o = {state == OWN1, state == OWN0};

endmodule

// File: tb/tb_wb_shared_arbiter.sv
// tb_wb_shared_arbiter: directed and random checks of the arbiter
// against a tenure-level reference model.
module tb_wb_shared_arbiter;

   localparam int TO = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        cyc, stb, we, ack, err;
   logic [1:0]        got_ack, got_err;
   logic [1:0][3:0]   sel;
   logic [1:0][31:0]  adr, wdat, rdat;
   logic              s_cyc_o, s_stb_o, s_we_o;
   logic [3:0]        s_sel_o;
   logic [31:0]       s_adr_o, s_dat_o, s_dat;
   logic              s_ack;
   logic [1:0]        grant_o;

   int nchk = 0;
   int nerr = 0;
   int own, lst, stall;

   always #5 clk = ~clk;

   wb_shared_arbiter #(.TIMEOUT(TO)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .m0_cyc_i (cyc[0]),
      .m0_stb_i (stb[0]),
      .m0_we_i  (we[0]),
      .m0_sel_i (sel[0]),
      .m0_adr_i (adr[0]),
      .m0_dat_i (wdat[0]),
      .m0_ack_o (ack[0]),
      .m0_err_o (err[0]),
      .m0_dat_o (rdat[0]),
      .m1_cyc_i (cyc[1]),
      .m1_stb_i (stb[1]),
      .m1_we_i  (we[1]),
      .m1_sel_i (sel[1]),
      .m1_adr_i (adr[1]),
      .m1_dat_i (wdat[1]),
      .m1_ack_o (ack[1]),
      .m1_err_o (err[1]),
      .m1_dat_o (rdat[1]),
      .s_cyc_o  (s_cyc_o),
      .s_stb_o  (s_stb_o),
      .s_we_o   (s_we_o),
      .s_sel_o  (s_sel_o),
      .s_adr_o  (s_adr_o),
      .s_dat_o  (s_dat_o),
      .s_dat_i  (s_dat),
      .s_ack_i  (s_ack),
      .grant_o  (grant_o)
   );

   // owner: -1 when nobody holds the slave; stall: unacked strobes so far
   task automatic model_reset();
      own   = -1;
      lst   = 1;
      stall = 0;
   endtask

   function automatic logic [140:0] expect_out();
      logic             e_cyc, e_stb, e_we;
      logic [3:0]       e_sel;
      logic [31:0]      e_adr, e_dat;
      logic [1:0]       e_ack, e_err, e_gnt;
      logic [1:0][31:0] e_rd;
      e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
      e_sel = '0; e_adr = '0; e_dat = '0;
      e_ack = '0; e_err = '0; e_gnt = '0; e_rd = '0;
      if (!rst && own >= 0) begin
         e_cyc = cyc[own];
         e_stb = stb[own];
         e_we  = we[own];
         e_sel = sel[own];
         e_adr = adr[own];
         e_dat = wdat[own];
         e_gnt[own] = 1'b1;
         e_rd[own]  = s_dat;
         e_ack[own] = s_ack;
         e_err[own] = !s_ack && stb[own] && (stall == TO - 1);
      end
      return {e_cyc, e_stb, e_we, e_sel, e_adr, e_dat,
              e_ack, e_err, e_rd, e_gnt};
   endfunction

   function automatic logic [140:0] obs_vec();
      return {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
              ack, err, rdat, grant_o};
   endfunction

   task automatic model_edge();
      bit r0, r1, fired;
      if (rst) begin
         model_reset();
         return;
      end
      if (own < 0) begin
         stall = 0;
         r0 = cyc[0] && stb[0];
         r1 = cyc[1] && stb[1];
         if (r0 && r1) own = (lst == 0) ? 1 : 0;
         else if (r0)  own = 0;
         else if (r1)  own = 1;
      end else begin
         fired = stb[own] && !s_ack && (stall == TO - 1);
         if (stb[own] && !s_ack && !fired) stall++;
         else stall = 0;
         if (!cyc[own]) begin
            lst = own;
            own = -1;
         end
      end
   endtask

   task automatic check_bus(string tag, logic [140:0] o, logic [140:0] e);
      nchk++;
      assert (o === e) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic check32(string tag, logic [31:0] o, logic [31:0] e);
      nchk++;
      assert (o === e) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic cyc_chk(string tag);
      @(negedge clk);
      got_ack = ack;
      got_err = err;
      check_bus(tag, obs_vec(), expect_out());
   endtask

   task automatic adv();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic setm(int n, bit c, bit s, bit w, logic [3:0] se,
                       logic [31:0] a, logic [31:0] d);
      cyc[n]  = c;
      stb[n]  = s;
      we[n]   = w;
      sel[n]  = se;
      adr[n]  = a;
      wdat[n] = d;
   endtask

   task automatic rnd_attr(int n);
      we[n]   = 1'($urandom_range(1));
      sel[n]  = 4'($urandom_range(15));
      adr[n]  = $urandom;
      wdat[n] = $urandom;
   endtask

   initial begin
      rst = 1'b1;
      cyc = '0; stb = '0; we = '0; sel = '0; adr = '0; wdat = '0;
      s_ack = 1'b0; s_dat = '0;
      got_ack = '0; got_err = '0;
      model_reset();
      cyc_chk("por");
      adv();
      rst = 1'b0;

      // asynchronous reset while m0 is strobing
      setm(0, 1, 1, 1, 4'hF, 32'h3000_0000, 32'h1111_1111);
      cyc_chk("r_req"); adv();
      cyc_chk("r_own0");
      check32("r_stb", 32'(s_stb_o), 32'd1);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_bus("r_async", obs_vec(), '0);
      adv();
      setm(1, 1, 1, 0, 4'hF, 32'h3000_0008, 32'h0);
      rst = 1'b0;
      cyc_chk("r_idle");
      check32("r_gnt_idle", 32'(grant_o), 32'd0);
      adv();
      cyc_chk("r_tie");
      check32("r_tie_gnt", 32'(grant_o), 32'd1);
      adv();
      setm(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
      setm(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
      cyc_chk("r_drop"); adv();
      cyc_chk("r_rel"); adv();

      // single read by m1, slave acks two cycles after its strobe
      setm(1, 1, 1, 0, 4'hF, 32'h3000_0004, 32'h0);
      cyc_chk("rd_req");
      check32("rd_lat", 32'(s_stb_o), 32'd0);
      adv();
      cyc_chk("rd_w0");
      check32("rd_stb", 32'(s_stb_o), 32'd1);
      adv();
      cyc_chk("rd_w1"); adv();
      s_ack = 1'b1;
      s_dat = 32'hDEAD_BEEF;
      cyc_chk("rd_ack");
      check32("rd_dat", rdat[1], 32'hDEAD_BEEF);
      check32("rd_ack1", 32'(ack[1]), 32'd1);
      check32("rd_ack0", 32'(ack[0]), 32'd0);
      adv();
      s_ack = 1'b0;
      s_dat = '0;
      setm(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
      cyc_chk("rd_drop"); adv();
      cyc_chk("rd_idle"); adv();

      // round robin: one acked write per tenure, then cyc drops
      s_ack = 1'b1;
      for (int i = 0; i < 12; i++) begin
         for (int n = 0; n < 2; n++) begin
            if (stb[n] && got_ack[n])
               setm(n, 0, 0, 0, 4'h0, 32'h0, 32'h0);
            else
               setm(n, 1, 1, 1, 4'hF, 32'h3000_0100 + 32'(n * 4), 32'(i));
         end
         cyc_chk("rr");
         check32("rr_gnt", 32'(grant_o),
                 (i % 3 == 0) ? 32'd0 : (((i / 3) % 2 == 0) ? 32'd1 : 32'd2));
         adv();
      end
      s_ack = 1'b0;
      setm(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
      setm(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
      cyc_chk("rr_end"); adv();

      // locked tenure: m0 keeps cyc across four writes, m1 waits
      setm(0, 1, 1, 1, 4'hF, 32'h3000_0010, 32'hA5A5_0000);
      cyc_chk("lk_req"); adv();
      for (int k = 0; k < 4; k++) begin
         setm(0, 1, 1, 1, 4'hF ^ 4'(k), 32'h3000_0010 + 32'(k * 4),
              32'hA5A5_0000 | 32'(k));
         setm(1, 1, 1, 0, 4'hF, 32'h3000_0200, 32'h0);
         s_ack = 1'b1;
         cyc_chk("lk_wr");
         check32("lk_adr", s_adr_o, 32'h3000_0010 + 32'(k * 4));
         check32("lk_dat", s_dat_o, 32'hA5A5_0000 | 32'(k));
         check32("lk_sel", 32'(s_sel_o), 32'(4'hF ^ 4'(k)));
         check32("lk_gnt", 32'(grant_o), 32'd1);
         adv();
      end
      setm(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
      s_ack = 1'b0;
      cyc_chk("lk_drop");
      check32("lk_drop_gnt", 32'(grant_o), 32'd1);
      adv();
      cyc_chk("lk_gap");
      check32("lk_gap_gnt", 32'(grant_o), 32'd0);
      adv();

      // timeout: m1 owns and the slave never acks
      for (int i = 0; i < TO; i++) begin
         cyc_chk("to");
         check32("to_gnt", 32'(grant_o), 32'd2);
         check32("to_err", 32'(err[1]), (i == TO - 1) ? 32'd1 : 32'd0);
         check32("to_ack", 32'(ack[1]), 32'd0);
         adv();
      end
      setm(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
      cyc_chk("to_drop");
      check32("to_drop_err", 32'(err[1]), 32'd0);
      adv();
      cyc_chk("to_idle");
      check32("to_idle_gnt", 32'(grant_o), 32'd0);
      adv();

      // ack lands in the timeout cycle; watchdog restarts from zero
      setm(0, 1, 1, 0, 4'hF, 32'h3000_0020, 32'h0);
      cyc_chk("col_req"); adv();
      for (int i = 0; i < 2 * TO; i++) begin
         s_ack = (i == TO - 1);
         cyc_chk("col");
         check32("col_ack", 32'(ack[0]), (i == TO - 1) ? 32'd1 : 32'd0);
         check32("col_err", 32'(err[0]), (i == 2 * TO - 1) ? 32'd1 : 32'd0);
         adv();
      end
      s_ack = 1'b0;
      setm(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
      cyc_chk("col_drop"); adv();
      cyc_chk("col_idle"); adv();

      // random legal traffic: strobes hold until ack or err
      for (int c = 0; c < 800; c++) begin
         for (int n = 0; n < 2; n++) begin
            if (!cyc[n]) begin
               if ($urandom_range(3) == 0) begin
                  cyc[n] = 1'b1;
                  stb[n] = 1'($urandom_range(1));
                  rnd_attr(n);
               end
            end else if (!stb[n] || got_ack[n] || got_err[n]) begin
               if ($urandom_range(2) == 0) begin
                  cyc[n] = 1'b0;
                  stb[n] = 1'b0;
               end else begin
                  stb[n] = 1'($urandom_range(1));
                  rnd_attr(n);
               end
            end
         end
         s_ack = ($urandom_range(99) < 35);
         s_dat = $urandom;
         cyc_chk("rnd");
         adv();
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
